// File: rtl/fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_add_sequencer
// Brief    : Control sequencer for a multi-cycle floating-point adder.
//            Steps compare/align/add/normalise and holds the result for a
//            ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_add_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              start_in,
    input  logic [DATA_WIDTH-1:0]             floating1_in,
    input  logic [DATA_WIDTH-1:0]             floating2_in,
    input  logic [EXPO_WIDTH:0]               exp_diff_in,
    input  logic [MENT_WIDTH+1:0]             sum_in,
    input  logic                              ready_in,
    output logic                              mux1_sel_out,
    output logic                              mux2_sel_out,
    output logic                              mux3_sel_out,
    output logic [EXPO_WIDTH-1:0]             rshift_out,
    output logic                              align_en_out,
    output logic                              add_en_out,
    output logic                              norm_en_out,
    output logic                              sub_op_out,
    output logic [$clog2(MENT_WIDTH+2):0]     normalize_position_out,
    output logic                              norm_valid_out,
    output logic                              zero_result_out,
    output logic                              special_out,
    output logic                              busy_out,
    output logic                              done_out
);

    // DATA_WIDTH is expected to equal 1 + EXPO_WIDTH + MENT_WIDTH.
    localparam int c_sum_w = MENT_WIDTH + 2;
    localparam int c_pos_w = $clog2(c_sum_w) + 1;
    localparam logic [EXPO_WIDTH:0]   c_sat_mag   = (EXPO_WIDTH+1)'(c_sum_w);
    localparam logic [EXPO_WIDTH-1:0] c_sat_shift = EXPO_WIDTH'(c_sum_w);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMP   = 3'd1,
        S_ALIGN = 3'd2,
        S_ADD   = 3'd3,
        S_NORM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_load_ops;

    logic                    r_sign1;
    logic                    r_sign2;
    logic [EXPO_WIDTH-1:0]   r_exp1;
    logic [EXPO_WIDTH-1:0]   r_exp2;

    logic                    r_mux_sel;
    logic [EXPO_WIDTH-1:0]   r_rshift;
    logic                    r_sub_op;
    logic                    r_special;
    logic [c_pos_w-1:0]      r_norm_pos;
    logic                    r_norm_valid;
    logic                    r_zero_result;

    logic                    w_special;
    logic [EXPO_WIDTH:0]     w_diff_mag;
    logic [EXPO_WIDTH-1:0]   w_rshift;
    logic [c_pos_w-1:0]      w_lead_pos;
    logic                    w_lead_found;
    logic                    w_unused_mant;

    // Only sign and exponent steer the sequencer; mantissas go to the datapath.
    assign w_unused_mant = ^{floating1_in[MENT_WIDTH-1:0], floating2_in[MENT_WIDTH-1:0]};

    assign w_special  = (&r_exp1) | (&r_exp2);
    assign w_diff_mag = exp_diff_in[EXPO_WIDTH] ? -exp_diff_in : exp_diff_in;
    assign w_rshift   = (w_diff_mag > c_sat_mag) ? c_sat_shift : w_diff_mag[EXPO_WIDTH-1:0];

    // Ascending scan: the last hit wins, which is the most significant one.
    always_comb begin
        w_lead_pos   = '0;
        w_lead_found = 1'b0;
        for (int i = 0; i < c_sum_w; i++) begin
            if (sum_in[i]) begin
                w_lead_pos   = c_pos_w'(i);
                w_lead_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        align_en_out = 1'b0;
        add_en_out   = 1'b0;
        norm_en_out  = 1'b0;
        done_out     = 1'b0;
        busy_out     = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy_out = 1'b0;
                if (start_in) w_state_next = S_CMP;
            end
            S_CMP: begin
                w_state_next = w_special ? S_DONE : S_ALIGN;
            end
            S_ALIGN: begin
                align_en_out = 1'b1;
                w_state_next = S_ADD;
            end
            S_ADD: begin
                add_en_out   = 1'b1;
                w_state_next = S_NORM;
            end
            S_NORM: begin
                norm_en_out  = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done_out = 1'b1;
                if (ready_in) w_state_next = start_in ? S_CMP : S_IDLE;
            end
            default: begin
                busy_out     = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operands are captured on every transition into CMP, from IDLE or DONE.
    assign w_load_ops = (w_state_next == S_CMP);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= S_IDLE;
            r_sign1       <= 1'b0;
            r_sign2       <= 1'b0;
            r_exp1        <= '0;
            r_exp2        <= '0;
            r_mux_sel     <= 1'b0;
            r_rshift      <= '0;
            r_sub_op      <= 1'b0;
            r_special     <= 1'b0;
            r_norm_pos    <= '0;
            r_norm_valid  <= 1'b0;
            r_zero_result <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_load_ops) begin
                r_sign1       <= floating1_in[DATA_WIDTH-1];
                r_sign2       <= floating2_in[DATA_WIDTH-1];
                r_exp1        <= floating1_in[DATA_WIDTH-2 -: EXPO_WIDTH];
                r_exp2        <= floating2_in[DATA_WIDTH-2 -: EXPO_WIDTH];
                r_special     <= 1'b0;
                r_norm_valid  <= 1'b0;
                r_zero_result <= 1'b0;
            end

            if (r_state == S_CMP) begin
                r_mux_sel <= ~exp_diff_in[EXPO_WIDTH];
                r_rshift  <= w_rshift;
                r_sub_op  <= r_sign1 ^ r_sign2;
                r_special <= w_special;
            end

            if (r_state == S_NORM) begin
                r_norm_pos    <= w_lead_pos;
                r_norm_valid  <= w_lead_found;
                r_zero_result <= ~w_lead_found;
            end
        end
    end

    assign mux1_sel_out           = r_mux_sel;
    assign mux2_sel_out           = r_mux_sel;
    assign mux3_sel_out           = r_mux_sel;
    assign rshift_out             = r_rshift;
    assign sub_op_out             = r_sub_op;
    assign special_out            = r_special;
    assign normalize_position_out = r_norm_pos;
    assign norm_valid_out         = r_norm_valid;
    assign zero_result_out        = r_zero_result;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_add_sequencer
// Brief    : Scoreboard bench for fp_add_sequencer using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        start_in;
    logic [31:0] floating1_in;
    logic [31:0] floating2_in;
    logic [8:0]  exp_diff_in;
    logic [24:0] sum_in;
    logic        ready_in;
    logic        mux1_sel_out;
    logic        mux2_sel_out;
    logic        mux3_sel_out;
    logic [7:0]  rshift_out;
    logic        align_en_out;
    logic        add_en_out;
    logic        norm_en_out;
    logic        sub_op_out;
    logic [5:0]  normalize_position_out;
    logic        norm_valid_out;
    logic        zero_result_out;
    logic        special_out;
    logic        busy_out;
    logic        done_out;

    fp_add_sequencer #(
        .DATA_WIDTH (32),
        .MENT_WIDTH (23),
        .EXPO_WIDTH (8)
    ) u_dut (
        .clk_in                 (clk_in),
        .rst_n_in               (rst_n_in),
        .start_in               (start_in),
        .floating1_in           (floating1_in),
        .floating2_in           (floating2_in),
        .exp_diff_in            (exp_diff_in),
        .sum_in                 (sum_in),
        .ready_in               (ready_in),
        .mux1_sel_out           (mux1_sel_out),
        .mux2_sel_out           (mux2_sel_out),
        .mux3_sel_out           (mux3_sel_out),
        .rshift_out             (rshift_out),
        .align_en_out           (align_en_out),
        .add_en_out             (add_en_out),
        .norm_en_out            (norm_en_out),
        .sub_op_out             (sub_op_out),
        .normalize_position_out (normalize_position_out),
        .norm_valid_out         (norm_valid_out),
        .zero_result_out        (zero_result_out),
        .special_out            (special_out),
        .busy_out               (busy_out),
        .done_out               (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit         mux;
        logic [7:0] rshift;
        bit         sub;
        bit         special;
        bit         valid;
        bit         zero;
        logic [5:0] pos;
        int         en;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    function automatic logic [31:0] outs();
        return 32'({mux1_sel_out, mux2_sel_out, mux3_sel_out, rshift_out,
                    align_en_out, add_en_out, norm_en_out, sub_op_out,
                    normalize_position_out, norm_valid_out, zero_result_out,
                    special_out, busy_out, done_out});
    endfunction

    function automatic exp_t mk(input bit mux, input logic [7:0] rsh, input bit sub,
                                input bit spc, input bit vld, input bit zro,
                                input logic [5:0] pos);
        exp_t e;
        e.mux = mux; e.rshift = rsh; e.sub = sub; e.special = spc;
        e.valid = vld; e.zero = zro; e.pos = pos;
        e.en = spc ? 0 : 3;
        e.done_cyc = 0;
        return e;
    endfunction

    // Monitor: compares every DONE cycle against the head of the scoreboard.
    initial begin : monitor
        int   en_cnt;
        bit   first;
        exp_t e;
        en_cnt = 0;
        first  = 1'b1;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                en_cnt = 0;
                first  = 1'b1;
            end else begin
                en_cnt += int'(align_en_out) + int'(add_en_out) + int'(norm_en_out);
                if (done_out) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(done_out), 32'(0));
                    end else begin
                        e = sb[0];
                        if (first) begin
                            chk("latency", cyc, e.done_cyc);
                            chk("enable_pulses", en_cnt, e.en);
                            first = 1'b0;
                        end
                        chk("mux1_sel", 32'(mux1_sel_out), 32'(e.mux));
                        chk("mux2_sel", 32'(mux2_sel_out), 32'(e.mux));
                        chk("mux3_sel", 32'(mux3_sel_out), 32'(e.mux));
                        chk("rshift", 32'(rshift_out), 32'(e.rshift));
                        chk("sub_op", 32'(sub_op_out), 32'(e.sub));
                        chk("special", 32'(special_out), 32'(e.special));
                        chk("norm_valid", 32'(norm_valid_out), 32'(e.valid));
                        chk("zero_result", 32'(zero_result_out), 32'(e.zero));
                        if (!e.special)
                            chk("norm_position", 32'(normalize_position_out), 32'(e.pos));
                        chk("busy_in_done", 32'(busy_out), 32'(1));
                        chk("enables_in_done", 32'({align_en_out, add_en_out, norm_en_out}), 32'(0));
                        if (ready_in) begin
                            void'(sb.pop_front());
                            first  = 1'b1;
                            en_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    // Starts one operation (optionally back-to-back from DONE), waits for done,
    // then holds ready low for 'hold' extra cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [8:0] ed, input logic [24:0] sm,
                          input exp_t e_in, input int hold, input bit chain);
        exp_t e;
        int   t;
        e = e_in;
        floating1_in = a;
        floating2_in = b;
        exp_diff_in  = ed;
        sum_in       = sm;
        start_in     = 1'b1;
        ready_in     = chain;
        e.done_cyc   = cyc + 1 + (e.special ? 1 : 4);
        sb.push_back(e);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        ready_in = 1'b0;
        if (chain) begin
            chk("b2b_busy", 32'(busy_out), 32'(1));
            chk("b2b_left_done", 32'(done_out), 32'(0));
        end
        t = 0;
        while (!done_out && t < 20) begin
            @(posedge clk_in); #1;
            t++;
        end
        if (!done_out) begin
            chk("done_timeout", 32'(done_out), 32'(1));
            finish_tb();
        end
        repeat (hold) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic release_result();
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        ready_in = 1'b0;
    endtask

    initial begin : stim
        bit saw;
        rst_n_in     = 1'b0;
        start_in     = 1'b0;
        ready_in     = 1'b0;
        floating1_in = '0;
        floating2_in = '0;
        exp_diff_in  = '0;
        sum_in       = '0;
        #3;
        chk("reset_outputs", outs(), 32'(0));
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // 1.0 + 2.0: operand swap, shift 1; held in DONE for 3 cycles then chained.
        run_op(32'h3F800000, 32'h40000000, 9'h1FF, 25'h0C00000, mk(0, 8'd1, 0, 0, 1, 0, 6'd23), 3, 0);
        run_op(32'h3F800000, 32'h3F800000, 9'd30, 25'h1000000, mk(1, 8'd25, 0, 0, 1, 0, 6'd24), 0, 1);
        release_result();
        run_op(32'hBF800000, 32'h3F800000, 9'd0, 25'h0, mk(1, 8'd0, 1, 0, 0, 1, 6'd0), 1, 0);
        release_result();
        run_op(32'h40400000, 32'h3F000000, 9'd2, 25'h1, mk(1, 8'd2, 0, 0, 1, 0, 6'd0), 0, 0);
        release_result();

        // Asynchronous reset while ALIGN is active.
        floating1_in = 32'h3F800000;
        floating2_in = 32'h40000000;
        exp_diff_in  = 9'h1FF;
        sum_in       = 25'h1;
        start_in     = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        @(posedge clk_in); #1;
        chk("align_active", 32'(align_en_out), 32'(1));
        #2 rst_n_in = 1'b0;
        #1 chk("reset_mid_op", outs(), 32'(0));
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_in); #1;
            saw |= done_out | busy_out;
        end
        chk("idle_after_reset", 32'(saw), 32'(0));

        // Special operands, including back-to-back chaining through DONE.
        run_op(32'h7F800000, 32'h3F800000, 9'h080, 25'h0, mk(1, 8'd25, 0, 1, 0, 0, 6'd0), 2, 0);
        run_op(32'h3F800000, 32'hFF800000, 9'h180, 25'h0, mk(0, 8'd25, 1, 1, 0, 0, 6'd0), 0, 1);
        run_op(32'hC1200000, 32'hC0A00000, 9'd1, 25'h0F00000, mk(1, 8'd1, 0, 0, 1, 0, 6'd23), 0, 1);
        release_result();
        run_op(32'h3F800000, 32'h4C000000, 9'h1E7, 25'h0000100, mk(0, 8'd25, 0, 0, 1, 0, 6'd8), 0, 0);
        release_result();
        run_op(32'h80800000, 32'h7F000000, 9'h100, 25'h1FFFFFF, mk(0, 8'd25, 1, 0, 1, 0, 6'd24), 0, 0);
        release_result();

        repeat (3) @(posedge clk_in);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        finish_tb();
    end

endmodule
`default_nettype wire

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, total float width; must equal 1+EXPO_WIDTH+MENT_WIDTH.
REQ-002 SHALL have parameter MENT_WIDTH, default 23, stored mantissa bits.
REQ-003 SHALL have parameter EXPO_WIDTH, default 8, exponent bits.
REQ-004 SHALL have port clk_in, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_in, input, 1, request to begin one addition.
REQ-007 SHALL have ports floating1_in and floating2_in, input, DATA_WIDTH each, operands {sign,exponent,mantissa}.
REQ-008 SHALL have port exp_diff_in, input, EXPO_WIDTH+1, two's-complement exponent1-exponent2 from compare stage.
REQ-009 SHALL have port sum_in, input, MENT_WIDTH+2, adder result including carry bit.
REQ-010 SHALL have port ready_in, input, 1, downstream accepts result.
REQ-011 SHALL have ports mux1_sel_out, mux2_sel_out, mux3_sel_out, output, 1 each, operand-swap selects.
REQ-012 SHALL have port rshift_out, output, EXPO_WIDTH, alignment shift magnitude.
REQ-013 SHALL have ports align_en_out, add_en_out, norm_en_out, output, 1 each, datapath stage enables.
REQ-014 SHALL have port sub_op_out, output, 1, effective subtraction (sign1 XOR sign2).
REQ-015 SHALL have port normalize_position_out, output, $clog2(MENT_WIDTH+2)+1, index of leading one in sum_in.
REQ-016 SHALL have ports norm_valid_out, zero_result_out, special_out, busy_out, done_out, output, 1 each.

Function
REQ-017 SHALL implement FSM states IDLE, CMP, ALIGN, ADD, NORM, DONE.
REQ-018 IDLE: start_in=1 at an edge -> CMP; operands latched into internal registers at that edge; otherwise stay IDLE.
REQ-019 CMP: latch exp_diff_in; mux*_sel_out = NOT exp_diff_in[EXPO_WIDTH], all three identical.
REQ-020 CMP: rshift_out = |exp_diff_in| (two's-complement negate when MSB set), saturated to MENT_WIDTH+2.
REQ-021 CMP: sub_op_out = sign1 XOR sign2 of latched operands; held until next CMP.
REQ-022 CMP: either latched exponent all-ones -> special_out=1, next state DONE (ALIGN/ADD/NORM skipped); else next ALIGN.
REQ-023 ALIGN, ADD, NORM: one cycle each; align_en_out, add_en_out, norm_en_out high only in the matching state.
REQ-024 NORM: scan sum_in from MSB to bit 0; register index of first 1 into normalize_position_out, norm_valid_out=1.
REQ-025 NORM: sum_in all zero -> normalize_position_out=0, norm_valid_out=0, zero_result_out=1.
REQ-026 DONE: done_out=1; held with all result outputs stable until ready_in=1.
REQ-027 DONE with ready_in=1 and start_in=1 at same edge -> CMP directly (back-to-back), new operands latched.
REQ-028 DONE with ready_in=1, start_in=0 -> IDLE; flags special_out, zero_result_out, norm_valid_out cleared on entering CMP.
REQ-029 busy_out=1 in every state except IDLE; start_in ignored in CMP, ALIGN, ADD, NORM.
REQ-030 Latency: start at edge 0 -> done_out high from cycle 5 (normal) or cycle 2 (special).
REQ-031 exp_diff_in=0 -> mux selects 1, rshift_out=0.

Reset
REQ-032 rst_n_in low SHALL force IDLE and all outputs to 0 immediately, independent of clk_in, including mid-operation.
REQ-033 After rst_n_in deasserts, first start_in is accepted on the next rising edge.

Verification
REQ-034 0x3F800000 + 0x40000000, exp_diff_in=9'h1FF -> mux sels 0, rshift_out=1, sub_op_out=0, done_out at cycle 5.
REQ-035 exp_diff_in=9'd30 -> mux sels 1, rshift_out=25 (saturated); 0xBF800000+0x3F800000 -> sub_op_out=1.
REQ-036 sum_in=25'h1000000 -> position 24, norm_valid 1; sum_in=25'h1 -> position 0, norm_valid 1; sum_in=0 -> zero_result_out=1, norm_valid 0.
REQ-037 floating1_in=0x7F800000 -> special_out=1, align/add/norm enables never high, done_out at cycle 2.
REQ-038 ready_in held low 3 cycles in DONE -> outputs stable; ready_in=1 with start_in=1 -> CMP next cycle, busy_out stays 1.
REQ-039 rst_n_in pulsed low during ALIGN -> all outputs 0 same cycle, FSM IDLE, no done_out.
